// File: rtl/spi_prog_loader.sv
// SPI program loader: buffers deserialized words and writes them into ICCM over TL-UL.
// Define PROG_LOADER_CHECKSUM_EN to add the running checksum_o output.
module spi_prog_loader #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int unsigned           FIFO_DEPTH = 4,
  parameter int unsigned           MAX_WORDS  = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  en_i,
  input  logic [DATA_WIDTH-1:0] rx_spi_inst_i,
  input  logic                  rx_spi_valid_i,
  output logic                  tl_a_valid_o,
  output logic [2:0]            tl_a_opcode_o,
  output logic [ADDR_WIDTH-1:0] tl_a_address_o,
  output logic [DATA_WIDTH-1:0] tl_a_data_o,
  output logic [3:0]            tl_a_mask_o,
  output logic [1:0]            tl_a_size_o,
  input  logic                  tl_a_ready_i,
  input  logic                  tl_d_valid_i,
  input  logic                  tl_d_error_i,
  output logic                  tl_d_ready_o,
  output logic [15:0]           word_count_o,
  output logic                  overflow_o,
  output logic                  error_o,
  output logic                  system_rst_no
`ifdef PROG_LOADER_CHECKSUM_EN
  ,
  output logic [31:0]           checksum_o
`endif
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(MAX_WORDS + 1);
  localparam logic [PW:0]   FULL_CNT = FIFO_DEPTH[PW:0];
  localparam logic [CW-1:0] MAX_CNT  = MAX_WORDS[CW-1:0];

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic [PW:0]           wr_q, wr_d, rd_q, rd_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [CW-1:0]         acc_q, acc_d;
  logic                  ovf_q, ovf_d;
  logic                  err_q, err_d;
  logic                  rel_q, rel_d;

  logic [PW:0] fifo_cnt;
  logic        fifo_empty, fifo_full;
  logic        pop, push, resp;

  always_comb begin
    fifo_cnt   = wr_q - rd_q;
    fifo_empty = (fifo_cnt == '0);
    fifo_full  = (fifo_cnt == FULL_CNT);
    pop        = (state_q == ST_REQ) && tl_a_ready_i;
    resp       = (state_q == ST_RESP) && tl_d_valid_i;
    // A full FIFO still accepts a word when the head leaves in the same cycle.
    push       = rx_spi_valid_i && (state_q != ST_DONE) && (acc_q < MAX_CNT) &&
                 (!fifo_full || pop);

    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    state_d = state_q;
    rel_d   = rel_q | (state_q == ST_DONE);

    if (push) begin
      mem_d[wr_q[PW-1:0]] = rx_spi_inst_i;
      wr_d                = wr_q + 1'b1;
      acc_d               = acc_q + 1'b1;
    end else if (rx_spi_valid_i) begin
      ovf_d = 1'b1;
    end
    if (pop) begin
      rd_d = rd_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          state_d = ST_REQ;
        end else if (en_i) begin
          state_d = ST_DONE;
        end
      end
      ST_REQ: begin
        if (tl_a_ready_i) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (tl_d_valid_i) begin
          ptr_d   = ptr_q + ADDR_WIDTH'(4);
          cnt_d   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
          err_d   = err_q | tl_d_error_i;
          state_d = fifo_empty ? ST_IDLE : ST_REQ;
        end
      end
      default: state_d = ST_DONE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      mem_q   <= '{default: '0};
      wr_q    <= '0;
      rd_q    <= '0;
      ptr_q   <= BASE_ADDR;
      cnt_q   <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
      rel_q   <= rel_d;
    end
  end

`ifdef PROG_LOADER_CHECKSUM_EN
  // The head is popped at the A handshake, so the in-flight word is kept for the D response.
  logic [DATA_WIDTH-1:0] fl_q, fl_d;
  logic [31:0]           csum_q, csum_d;

  always_comb begin
    fl_d   = pop ? mem_q[rd_q[PW-1:0]] : fl_q;
    csum_d = (resp && !tl_d_error_i) ? csum_q + fl_q : csum_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fl_q   <= '0;
      csum_q <= '0;
    end else begin
      fl_q   <= fl_d;
      csum_q <= csum_d;
    end
  end

  assign checksum_o = csum_q;
`endif

  assign tl_a_valid_o   = (state_q == ST_REQ);
  assign tl_a_opcode_o  = 3'h0;
  assign tl_a_address_o = ptr_q;
  assign tl_a_data_o    = mem_q[rd_q[PW-1:0]];
  assign tl_a_mask_o    = 4'hF;
  assign tl_a_size_o    = 2'h2;
  assign tl_d_ready_o   = (state_q == ST_RESP);
  assign word_count_o   = cnt_q;
  assign overflow_o     = ovf_q;
  assign error_o        = err_q;
  assign system_rst_no  = rel_q;

endmodule

// File: tb/tb_spi_prog_loader.sv
// Bench for spi_prog_loader: queue-based transaction model checked every cycle, plus directed literals.
module tb_spi_prog_loader;
  localparam int          DEPTH = 4;
  localparam int          MAXW  = 16;
  localparam logic [31:0] BASE  = 32'h0;

  localparam int PH_IDLE = 0;
  localparam int PH_REQ  = 1;
  localparam int PH_RESP = 2;
  localparam int PH_DONE = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        rx_valid = 1'b0;
  logic [31:0] rx_data = '0;
  logic        a_ready = 1'b0;
  logic        d_valid = 1'b0;
  logic        d_error = 1'b0;

  logic        tl_a_valid_o;
  logic [2:0]  tl_a_opcode_o;
  logic [31:0] tl_a_address_o;
  logic [31:0] tl_a_data_o;
  logic [3:0]  tl_a_mask_o;
  logic [1:0]  tl_a_size_o;
  logic        tl_d_ready_o;
  logic [15:0] word_count_o;
  logic        overflow_o;
  logic        error_o;
  logic        system_rst_no;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [31:0] checksum_o;
`endif

  always #5 clk = ~clk;

  spi_prog_loader #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32),
    .BASE_ADDR (BASE),
    .FIFO_DEPTH(DEPTH),
    .MAX_WORDS (MAXW)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .en_i          (en),
    .rx_spi_inst_i (rx_data),
    .rx_spi_valid_i(rx_valid),
    .tl_a_valid_o  (tl_a_valid_o),
    .tl_a_opcode_o (tl_a_opcode_o),
    .tl_a_address_o(tl_a_address_o),
    .tl_a_data_o   (tl_a_data_o),
    .tl_a_mask_o   (tl_a_mask_o),
    .tl_a_size_o   (tl_a_size_o),
    .tl_a_ready_i  (a_ready),
    .tl_d_valid_i  (d_valid),
    .tl_d_error_i  (d_error),
    .tl_d_ready_o  (tl_d_ready_o),
    .word_count_o  (word_count_o),
    .overflow_o    (overflow_o),
    .error_o       (error_o),
    .system_rst_no (system_rst_no)
`ifdef PROG_LOADER_CHECKSUM_EN
    ,
    .checksum_o    (checksum_o)
`endif
  );

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // Reference model: words waiting in a queue, one phase of the single outstanding write.
  logic [31:0] m_q[$];
  int          m_ph;
  logic [31:0] m_ptr;
  int          m_cnt;
  int          m_acc;
  bit          m_ovf, m_err, m_rel;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [31:0] m_fl, m_csum;
`endif

  task automatic model_reset();
    m_q.delete();
    m_ph  = PH_IDLE;
    m_ptr = BASE;
    m_cnt = 0;
    m_acc = 0;
    m_ovf = 1'b0;
    m_err = 1'b0;
    m_rel = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
    m_fl   = '0;
    m_csum = '0;
`endif
  endtask

  task automatic model_step();
    int sz;
    bit had_word, leaving, take;
    sz       = m_q.size();
    had_word = (sz > 0);
    leaving  = (m_ph == PH_REQ) && a_ready;
    take     = rx_valid && (m_ph != PH_DONE) && (m_acc < MAXW) && ((sz < DEPTH) || leaving);
    if (m_ph == PH_DONE) m_rel = 1'b1;
    case (m_ph)
      PH_IDLE: if (had_word) m_ph = PH_REQ; else if (en) m_ph = PH_DONE;
      PH_REQ: if (a_ready) begin
`ifdef PROG_LOADER_CHECKSUM_EN
        m_fl = m_q.pop_front();
`else
        void'(m_q.pop_front());
`endif
        m_ph = PH_RESP;
      end
      PH_RESP: if (d_valid) begin
        m_ptr = m_ptr + 32'd4;
        if (m_cnt < 65535) m_cnt++;
        if (d_error) m_err = 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
        else m_csum = m_csum + m_fl;
`endif
        m_ph = had_word ? PH_REQ : PH_IDLE;
      end
      default: m_ph = PH_DONE;
    endcase
    if (take) begin
      m_q.push_back(rx_data);
      m_acc++;
    end else if (rx_valid) begin
      m_ovf = 1'b1;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  logic [31:0] a_log[$];
  logic [3:0]  mask_log[$];

  // Per-cycle comparison; inputs change 1 time unit after posedge, so negedge sees the next edge's inputs.
  initial begin
    forever begin
      @(negedge clk);
      chk("a_valid", 32'(tl_a_valid_o), 32'(m_ph == PH_REQ));
      chk("d_ready", 32'(tl_d_ready_o), 32'(m_ph == PH_RESP));
      chk("word_count", 32'(word_count_o), 32'(m_cnt));
      chk("overflow", 32'(overflow_o), 32'(m_ovf));
      chk("error", 32'(error_o), 32'(m_err));
      chk("sys_rst_n", 32'(system_rst_no), 32'(m_rel));
      chk("opcode", 32'(tl_a_opcode_o), 32'h0);
      chk("mask", 32'(tl_a_mask_o), 32'hF);
      chk("size", 32'(tl_a_size_o), 32'h2);
`ifdef PROG_LOADER_CHECKSUM_EN
      chk("checksum", checksum_o, m_csum);
`endif
      if (m_ph == PH_REQ && m_q.size() > 0) begin
        chk("a_address", tl_a_address_o, m_ptr);
        chk("a_data", tl_a_data_o, m_q[0]);
      end
      if (tl_a_valid_o && a_ready) begin
        a_log.push_back(tl_a_address_o);
        mask_log.push_back(tl_a_mask_o);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cyc();
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    en       = 1'b0;
    a_ready  = 1'b0;
    d_valid  = 1'b0;
    d_error  = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
    a_log.delete();
    mask_log.delete();
  endtask

  task automatic strobe(input logic [31:0] w);
    cyc();
    rx_valid = 1'b1;
    rx_data  = w;
    cyc();
    rx_valid = 1'b0;
  endtask

  function automatic logic [31:0] wv(input int i);
    return 32'hA000_0000 + 32'(i);
  endfunction

  initial begin
    logic [31:0] prog[3];
    bit rose;
    prog[0] = 32'h0000_0013;
    prog[1] = 32'h0010_0093;
    prog[2] = 32'h0000_006F;

    @(negedge clk);
    chk("rst_a_valid", 32'(tl_a_valid_o), 32'h0);
    chk("rst_d_ready", 32'(tl_d_ready_o), 32'h0);
    chk("rst_sys_rst_n", 32'(system_rst_no), 32'h0);
    chk("rst_count", 32'(word_count_o), 32'h0);
    chk("rst_ovf_err", 32'({overflow_o, error_o}), 32'h0);

    // Three program words, one write each, then release.
    do_reset();
    a_ready = 1'b1;
    d_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      strobe(prog[i]);
      repeat (34) cyc();
    end
    @(negedge clk);
    chk("t1_nwrites", 32'(a_log.size()), 32'd3);
    if (a_log.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        chk("t1_addr", a_log[i], 32'(4 * i));
        chk("t1_mask", 32'(mask_log[i]), 32'hF);
      end
    end
    chk("t1_count", 32'(word_count_o), 32'd3);
    cyc();
    en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t1_rst_hold", 32'(system_rst_no), 32'h0);
    @(negedge clk);
    chk("t1_rst_rise", 32'(system_rst_no), 32'h1);

    // Stall with one write in flight and the FIFO filling.
    do_reset();
    a_ready = 1'b1;
    strobe(wv(1));
    cyc();
    cyc();
    a_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      rx_valid = 1'b1;
      rx_data  = wv(i + 2);
      if (i == 4) begin
        @(negedge clk);
        chk("t2_no_ovf_yet", 32'(overflow_o), 32'h0);
      end
    end
    cyc();
    rx_valid = 1'b0;
    @(negedge clk);
    chk("t2_ovf_6th", 32'(overflow_o), 32'h1);
    cyc();
    d_valid = 1'b1;
    cyc();
    d_valid = 1'b0;
    repeat (20) begin
      @(negedge clk);
      chk("t2_stall_valid", 32'(tl_a_valid_o), 32'h1);
      chk("t2_stall_addr", tl_a_address_o, 32'h4);
      chk("t2_stall_data", tl_a_data_o, wv(2));
      cyc();
    end
    a_ready = 1'b1;
    d_valid = 1'b1;
    repeat (30) cyc();
    @(negedge clk);
    chk("t2_count", 32'(word_count_o), 32'd5);
    chk("t2_ovf_sticky", 32'(overflow_o), 32'h1);

    // Release requested while two words are still buffered.
    do_reset();
    a_ready = 1'b1;
    cyc();
    rx_valid = 1'b1;
    rx_data  = wv(10);
    cyc();
    rx_data = wv(11);
    cyc();
    rx_valid = 1'b0;
    en       = 1'b1;
    d_valid  = 1'b1;
    rose     = 1'b0;
    for (int i = 0; i < 40 && !rose; i++) begin
      @(negedge clk);
      if (system_rst_no) begin
        rose = 1'b1;
        chk("t3_count_at_release", 32'(word_count_o), 32'd2);
      end else if (word_count_o < 16'd2) begin
        chk("t3_rst_held", 32'(system_rst_no), 32'h0);
      end
      cyc();
    end
    chk("t3_released", 32'(rose), 32'h1);

    // Error on the second response only.
    do_reset();
    a_ready = 1'b1;
    d_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      strobe(wv(20 + i));
      repeat (6) begin
        cyc();
        d_error = (word_count_o == 16'd1);
      end
    end
    repeat (10) cyc();
    @(negedge clk);
    chk("t4_error", 32'(error_o), 32'h1);
    chk("t4_count", 32'(word_count_o), 32'd3);
    chk("t4_nwrites", 32'(a_log.size()), 32'd3);
    if (a_log.size() == 3) chk("t4_addr3", a_log[2], 32'h8);

    // Asynchronous reset while waiting for a response.
    do_reset();
    a_ready = 1'b1;
    strobe(wv(30));
    cyc();
    cyc();
    @(negedge clk);
    chk("t5_in_resp", 32'(tl_d_ready_o), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_d_ready", 32'(tl_d_ready_o), 32'h0);
    chk("t5_async_valid", 32'(tl_a_valid_o), 32'h0);
    chk("t5_async_flags", 32'({overflow_o, error_o, system_rst_no}), 32'h0);
    chk("t5_async_count", 32'(word_count_o), 32'h0);
    cyc();
    rst_n   = 1'b1;
    d_valid = 1'b1;
    a_log.delete();
    strobe(wv(31));
    repeat (6) cyc();
    @(negedge clk);
    chk("t5_nwrites", 32'(a_log.size()), 32'd1);
    if (a_log.size() > 0) chk("t5_base_addr", a_log[0], BASE);

`ifdef PROG_LOADER_CHECKSUM_EN
    do_reset();
    a_ready = 1'b1;
    d_valid = 1'b1;
    strobe(32'hFFFF_FFFF);
    repeat (6) cyc();
    strobe(32'h0000_0002);
    repeat (6) cyc();
    @(negedge clk);
    chk("csum_wrap", checksum_o, 32'h0000_0001);
`endif

    // Randomised traffic, including MAX_WORDS exhaustion and late release.
    for (int r = 0; r < 4; r++) begin
      do_reset();
      for (int i = 0; i < 600; i++) begin
        cyc();
        rx_valid = ($urandom % 3) == 0;
        rx_data  = $urandom;
        a_ready  = ($urandom % 4) != 0;
        d_valid  = ($urandom % 3) != 0;
        d_error  = ($urandom % 8) == 0;
        if (i > 400 && ($urandom % 50) == 0) en = 1'b1;
      end
    end

    cyc();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
